// File: rtl/if_id_stage.sv
// Instruction-fetch stage with PC register, PC+4 adder, branch redirect and the IF/ID
// pipeline register; also counts stall and flush cycles for debug visibility.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        ifid_write_i,
    input  logic        id_flush_i,
    input  logic        pc_src_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_valid_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic [31:0] w_ifid_instr_next;
    logic [31:0] w_ifid_pc_plus4_next;
    logic        w_ifid_valid_next;
    logic        w_stall_evt;
    logic [15:0] w_stall_cnt_next;
    logic [15:0] w_flush_cnt_next;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-PC select: a taken branch beats a load-use stall.
    always_comb begin
        w_pc_next = r_pc;
        if (pc_src_i) begin
            w_pc_next = {branch_target_i[31:2], 2'b00};
        end else if (pc_write_i) begin
            w_pc_next = w_pc_plus4;
        end else begin
            w_pc_next = r_pc;
        end
    end

    // IF/ID next state: a flush beats both load and hold.
    always_comb begin
        w_ifid_instr_next    = r_ifid_instr;
        w_ifid_pc_plus4_next = r_ifid_pc_plus4;
        w_ifid_valid_next    = r_ifid_valid;
        if (id_flush_i) begin
            w_ifid_instr_next    = 32'h0000_0000;
            w_ifid_pc_plus4_next = 32'h0000_0000;
            w_ifid_valid_next    = 1'b0;
        end else if (ifid_write_i) begin
            w_ifid_instr_next    = instr_i;
            w_ifid_pc_plus4_next = w_pc_plus4;
            w_ifid_valid_next    = 1'b1;
        end else begin
            w_ifid_instr_next    = r_ifid_instr;
            w_ifid_pc_plus4_next = r_ifid_pc_plus4;
            w_ifid_valid_next    = r_ifid_valid;
        end
    end

    // Saturating event counters; a redirect is not a stall even with pc_write_i low.
    always_comb begin
        w_stall_evt      = ~pc_write_i & ~pc_src_i;
        w_stall_cnt_next = r_stall_cnt;
        w_flush_cnt_next = r_flush_cnt;
        if (w_stall_evt) begin
            w_stall_cnt_next = sat_inc(r_stall_cnt);
        end else begin
            w_stall_cnt_next = r_stall_cnt;
        end
        if (id_flush_i) begin
            w_flush_cnt_next = sat_inc(r_flush_cnt);
        end else begin
            w_flush_cnt_next = r_flush_cnt;
        end
    end

    // PC register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC_ALIGNED;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ifid_instr    <= 32'h0000_0000;
            r_ifid_pc_plus4 <= 32'h0000_0000;
            r_ifid_valid    <= 1'b0;
        end else begin
            r_ifid_instr    <= w_ifid_instr_next;
            r_ifid_pc_plus4 <= w_ifid_pc_plus4_next;
            r_ifid_valid    <= w_ifid_valid_next;
        end
    end

    // Stall and flush counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            r_stall_cnt <= w_stall_cnt_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    assign pc_o            = r_pc;
    assign ifid_instr_o    = r_ifid_instr;
    assign ifid_pc_plus4_o = r_ifid_pc_plus4;
    assign ifid_valid_o    = r_ifid_valid;
    assign stall_cnt_o     = r_stall_cnt;
    assign flush_cnt_o     = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage: reset, fetch, stall, branch/flush,
// wrap-around, counter saturation and asynchronous reset.
module tb_if_id_stage;

    logic        clk_i;
    logic        rst_i;
    logic        pc_write_i;
    logic        ifid_write_i;
    logic        id_flush_i;
    logic        pc_src_i;
    logic [31:0] branch_target_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_plus4_o;
    logic        ifid_valid_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int n_checks;
    int n_pass;

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_write_i      (pc_write_i),
        .ifid_write_i    (ifid_write_i),
        .id_flush_i      (id_flush_i),
        .pc_src_i        (pc_src_i),
        .branch_target_i (branch_target_i),
        .instr_i         (instr_i),
        .pc_o            (pc_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o),
        .ifid_valid_o    (ifid_valid_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl, input logic ps,
                         input logic [31:0] tgt, input logic [31:0] ins);
        pc_write_i      = pw;
        ifid_write_i    = iw;
        id_flush_i      = fl;
        pc_src_i        = ps;
        branch_target_i = tgt;
        instr_i         = ins;
    endtask

    task automatic test_reset();
        rst_i           = 1'b1;
        pc_write_i      = 1'bx;
        ifid_write_i    = 1'bx;
        id_flush_i      = 1'bx;
        pc_src_i        = 1'bx;
        branch_target_i = 32'hxxxx_xxxx;
        instr_i         = 32'hxxxx_xxxx;
        step();
        step();
        n_checks++; if (pc_o !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'h0) $display("FAIL reset_instr got=%h exp=0", ifid_instr_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h0) $display("FAIL reset_pc4 got=%h exp=0", ifid_pc_plus4_o); else n_pass++;
        n_checks++; if (ifid_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ifid_valid_o); else n_pass++;
        n_checks++; if (stall_cnt_o !== 16'h0) $display("FAIL reset_stall got=%h exp=0", stall_cnt_o); else n_pass++;
        n_checks++; if (flush_cnt_o !== 16'h0) $display("FAIL reset_flush got=%h exp=0", flush_cnt_o); else n_pass++;
    endtask

    task automatic test_sequential_fetch();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hAAAA_0001);
        rst_i = 1'b0;
        step();
        n_checks++; if (pc_o !== 32'h4) $display("FAIL seq1_pc got=%h exp=4", pc_o); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'hAAAA_0001) $display("FAIL seq1_instr got=%h exp=aaaa0001", ifid_instr_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h4) $display("FAIL seq1_pc4 got=%h exp=4", ifid_pc_plus4_o); else n_pass++;
        n_checks++; if (ifid_valid_o !== 1'b1) $display("FAIL seq1_valid got=%b exp=1", ifid_valid_o); else n_pass++;
        instr_i = 32'hAAAA_0002;
        step();
        n_checks++; if (pc_o !== 32'h8) $display("FAIL seq2_pc got=%h exp=8", pc_o); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'hAAAA_0002) $display("FAIL seq2_instr got=%h exp=aaaa0002", ifid_instr_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h8) $display("FAIL seq2_pc4 got=%h exp=8", ifid_pc_plus4_o); else n_pass++;
        n_checks++; if (stall_cnt_o !== 16'h0) $display("FAIL seq2_stall got=%h exp=0", stall_cnt_o); else n_pass++;
    endtask

    task automatic test_load_use_stall();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hBBBB_0003);
        step();
        step();
        n_checks++; if (pc_o !== 32'h8) $display("FAIL stall_pc got=%h exp=8", pc_o); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'hAAAA_0002) $display("FAIL stall_instr got=%h exp=aaaa0002", ifid_instr_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h8) $display("FAIL stall_pc4 got=%h exp=8", ifid_pc_plus4_o); else n_pass++;
        n_checks++; if (ifid_valid_o !== 1'b1) $display("FAIL stall_valid got=%b exp=1", ifid_valid_o); else n_pass++;
        n_checks++; if (stall_cnt_o !== 16'd2) $display("FAIL stall_cnt got=%0d exp=2", stall_cnt_o); else n_pass++;
    endtask

    task automatic test_branch_during_stall();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'hBBBB_0004);
        step();
        n_checks++; if (pc_o !== 32'h100) $display("FAIL br_pc got=%h exp=100", pc_o); else n_pass++;
        n_checks++; if (ifid_valid_o !== 1'b0) $display("FAIL br_valid got=%b exp=0", ifid_valid_o); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'h0) $display("FAIL br_instr got=%h exp=0", ifid_instr_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h0) $display("FAIL br_pc4 got=%h exp=0", ifid_pc_plus4_o); else n_pass++;
        n_checks++; if (stall_cnt_o !== 16'd2) $display("FAIL br_stall got=%0d exp=2", stall_cnt_o); else n_pass++;
        n_checks++; if (flush_cnt_o !== 16'd1) $display("FAIL br_flush got=%0d exp=1", flush_cnt_o); else n_pass++;
        // Flush also beats ifid_write_i=1.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'hBBBB_0005);
        step();
        n_checks++; if (pc_o !== 32'h104) $display("FAIL fl2_pc got=%h exp=104", pc_o); else n_pass++;
        n_checks++; if (ifid_valid_o !== 1'b0) $display("FAIL fl2_valid got=%b exp=0", ifid_valid_o); else n_pass++;
        n_checks++; if (flush_cnt_o !== 16'd2) $display("FAIL fl2_flush got=%0d exp=2", flush_cnt_o); else n_pass++;
    endtask

    task automatic test_wrap_around();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hCCCC_0001);
        step();
        n_checks++; if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_br_pc got=%h exp=fffffffc", pc_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h108) $display("FAIL wrap_br_pc4 got=%h exp=108", ifid_pc_plus4_o); else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hCCCC_0002);
        step();
        n_checks++; if (pc_o !== 32'h0) $display("FAIL wrap_pc got=%h exp=0", pc_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h0) $display("FAIL wrap_pc4 got=%h exp=0", ifid_pc_plus4_o); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'hCCCC_0002) $display("FAIL wrap_instr got=%h exp=cccc0002", ifid_instr_o); else n_pass++;
        n_checks++; if (stall_cnt_o !== 16'd2) $display("FAIL wrap_stall got=%0d exp=2", stall_cnt_o); else n_pass++;
    endtask

    task automatic test_saturation();
        #2;
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDDDD_0000);
        for (int i = 0; i < 65534; i++) step();
        n_checks++; if (stall_cnt_o !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", stall_cnt_o); else n_pass++;
        for (int i = 0; i < 6; i++) step();
        n_checks++; if (stall_cnt_o !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", stall_cnt_o); else n_pass++;
        n_checks++; if (flush_cnt_o !== 16'h0) $display("FAIL sat_flush got=%h exp=0", flush_cnt_o); else n_pass++;
        n_checks++; if (pc_o !== 32'h0) $display("FAIL sat_pc got=%h exp=0", pc_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDDDD_0001);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDDDD_0002);
        step();
        n_checks++; if (pc_o !== 32'h4) $display("FAIL ar_pre_pc got=%h exp=4", pc_o); else n_pass++;
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++; if (pc_o !== 32'h0) $display("FAIL ar_pc got=%h exp=0", pc_o); else n_pass++;
        n_checks++; if (ifid_valid_o !== 1'b0) $display("FAIL ar_valid got=%b exp=0", ifid_valid_o); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'h0) $display("FAIL ar_instr got=%h exp=0", ifid_instr_o); else n_pass++;
        n_checks++; if (stall_cnt_o !== 16'h0) $display("FAIL ar_stall got=%h exp=0", stall_cnt_o); else n_pass++;
        n_checks++; if (flush_cnt_o !== 16'h0) $display("FAIL ar_flush got=%h exp=0", flush_cnt_o); else n_pass++;
        rst_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hEEEE_0001);
        step();
        n_checks++; if (pc_o !== 32'h4) $display("FAIL post_pc got=%h exp=4", pc_o); else n_pass++;
        n_checks++; if (ifid_instr_o !== 32'hEEEE_0001) $display("FAIL post_instr got=%h exp=eeee0001", ifid_instr_o); else n_pass++;
        n_checks++; if (ifid_pc_plus4_o !== 32'h4) $display("FAIL post_pc4 got=%h exp=4", ifid_pc_plus4_o); else n_pass++;
        n_checks++; if (ifid_valid_o !== 1'b1) $display("FAIL post_valid got=%b exp=1", ifid_valid_o); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_sequential_fetch();
        test_load_use_stall();
        test_branch_during_stall();
        test_wrap_around();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
